mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder of the accumulator's memory interface: a DEPTH x DATA_WIDTH word store
//  answering mem_address / mem_read_enable / mem_write_enable / mem_data_in with mem_data_out.
//  After reset it sweeps every word to INIT_VALUE, then serves requests. It also counts accepted
//  and rejected accesses for bench observability.
// PARAMETERS
//  ADDR_WIDTH  5       address bits; DEPTH = 2**ADDR_WIDTH words (32)
//  DATA_WIDTH  16      word width
//  INIT_VALUE  16'h0   value written to every word during the post-reset clear sweep
//  CNT_WIDTH   16      width of each saturating access counter
// PORTS
//  clk               in   1           rising-edge clock, single clock domain
//  reset             in   1           synchronous, active-high; restarts the clear sweep
//  mem_address       in   ADDR_WIDTH  word address of the current request
//  mem_read_enable   in   1           read request, sampled each rising edge
//  mem_write_enable  in   1           write request, sampled each rising edge
//  mem_data_in       in   DATA_WIDTH  write data
//  mem_data_out      out  DATA_WIDTH  registered read data
//  init_done         out  1           1 = clear sweep finished, requests are served
//  rd_count          out  CNT_WIDTH   accepted reads, saturating
//  wr_count          out  CNT_WIDTH   accepted writes, saturating
//  reject_count      out  CNT_WIDTH   requests dropped during CLEAR, saturating
// BEHAVIOUR
//  Reset (sync, active-high): state=CLEAR, clr_addr=0, init_done=0, mem_data_out=0, all counters=0.
//   - No array write happens on an edge where reset=1.
//   - Asserted mid-operation: same result; stored data is lost after the next sweep.
//  State CLEAR:
//   - Each edge with reset=0 writes INIT_VALUE to mem[clr_addr], then clr_addr++.
//   - The edge that writes word DEPTH-1 also moves to SERVE and sets init_done=1.
//   - So init_done rises exactly DEPTH (32) edges after reset release.
//   - Any edge with read or write enable=1: request ignored, reject_count += 1.
//   - Read+write together count as one reject.
//   - mem_data_out holds its value.
//  State SERVE (stays until reset):
//   - write_enable=1: mem[mem_address] <= mem_data_in on that edge; wr_count += 1.
//   - read_enable=1: mem_data_out <= mem[mem_address] on that edge, so 1-cycle read latency.
//     rd_count += 1.
//   - Both =1 on the same edge: both accepted; rd and wr counters each +1.
//     Same address: read returns the OLD word (read-first); the new word is visible from the next read.
//   - read_enable=0: mem_data_out holds its last value (no bus release / zeroing).
//   - Both =0: no state change.
//  Counters saturate at 2**CNT_WIDTH-1; no wrap.
//  Address: full ADDR_WIDTH decode; every address is valid; no out-of-range case.
//  No back-pressure: the accumulator FSM gets its data one cycle after asserting read and must
//   not issue requests before init_done=1.
// TESTING
//  T1 release reset, idle -> init_done=0 for 31 edges, 1 after edge 32; read addr 7 -> mem_data_out=0x0000 next cycle
//  T2 SERVE: write 0x1234 @3, next cycle read @3 -> mem_data_out=0x1234 one cycle later; wr_count=1, rd_count=1
//  T3 mem[5]=0xAAAA; same-edge read+write @5 data 0x5555 -> out 0xAAAA; following read @5 -> 0x5555
//  T4 write 0xBEEF @9 on edge 10 after release -> ignored, reject_count=1; after init read @9 -> 0x0000
//  T5 write 0x00FF @1..4, pulse reset 1 cycle -> counters 0, init_done=0; after sweep read @2 -> 0x0000
//  T6 CNT_WIDTH=4: 20 reads in SERVE -> rd_count=15, stays 15; wr_count=0

Source files
------------

// File: rtl/mem_responder.sv
// Word store behind the accumulator's memory port: clears itself to INIT_VALUE after reset,
// then serves single-cycle writes and 1-cycle-latency reads, with saturating access counters.
module mem_responder #(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic                  mem_read_enable,
  input  logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  init_done,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [CNT_WIDTH-1:0]  reject_count,
  output logic                  state_dbg_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {CLEAR = 1'b0, SERVE = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic [CNT_WIDTH-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CNT_WIDTH-1:0]    wr_cnt_q, wr_cnt_d;
  logic [CNT_WIDTH-1:0]    rej_cnt_q, rej_cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    data_out_d = data_out_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    rej_cnt_d  = rej_cnt_q;
    mem_we     = 1'b0;
    mem_waddr  = mem_address;
    mem_wdata  = mem_data_in;
    case (state_q)
      CLEAR: begin
        mem_we     = 1'b1;
        mem_waddr  = clr_addr_q;
        mem_wdata  = INIT_VALUE;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == '1) state_d = SERVE;
        // Simultaneous read+write is a single dropped request.
        if (mem_read_enable || mem_write_enable) rej_cnt_d = sat_inc(rej_cnt_q);
      end
      SERVE: begin
        if (mem_write_enable) begin
          mem_we   = 1'b1;
          wr_cnt_d = sat_inc(wr_cnt_q);
        end
        if (mem_read_enable) begin
          data_out_d = mem_q[mem_address];
          rd_cnt_d   = sat_inc(rd_cnt_q);
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      data_out_q <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      rej_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      data_out_q <= data_out_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      rej_cnt_q  <= rej_cnt_d;
    end
  end

  // Array update reads the old word above in the same cycle, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign mem_data_out = data_out_q;
  assign init_done    = (state_q == SERVE);
  assign rd_count     = rd_cnt_q;
  assign wr_count     = wr_cnt_q;
  assign reject_count = rej_cnt_q;
  assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a reference model tracks memory contents and access totals,
// compared every cycle against a 16-bit-counter and a 4-bit-counter instance sharing one bus.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  mem_address;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [15:0] mem_data_in;

  logic [15:0] dout_a, dout_b;
  logic        done_a, done_b, st_a, st_b;
  logic [15:0] rd_a, wr_a, rej_a;
  logic [3:0]  rd_b, wr_b, rej_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(5), .DATA_WIDTH(16), .INIT_VALUE(16'h0), .CNT_WIDTH(16)) u_main (
    .clk(clk), .reset(reset), .mem_address(mem_address),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_data_in(mem_data_in), .mem_data_out(dout_a), .init_done(done_a),
    .rd_count(rd_a), .wr_count(wr_a), .reject_count(rej_a), .state_dbg_o(st_a)
  );

  mem_responder #(.ADDR_WIDTH(5), .DATA_WIDTH(16), .INIT_VALUE(16'h0), .CNT_WIDTH(4)) u_sat (
    .clk(clk), .reset(reset), .mem_address(mem_address),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_data_in(mem_data_in), .mem_data_out(dout_b), .init_done(done_b),
    .rd_count(rd_b), .wr_count(wr_b), .reject_count(rej_b), .state_dbg_o(st_b)
  );

  // ---------------- reference model ----------------
  logic [15:0] m_mem [32];
  int          m_edges_since_reset;
  logic [15:0] m_out;
  int          m_rd, m_wr, m_rej;
  bit          m_valid = 1'b0;

  function automatic int sat(input int v, input int w);
    int lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  function automatic bit m_ready();
    return m_edges_since_reset >= 32;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid             = 1'b1;
      m_edges_since_reset = 0;
      m_out               = 16'h0;
      m_rd = 0; m_wr = 0; m_rej = 0;
    end else if (m_valid) begin
      if (!m_ready()) begin
        // Sweep position equals the number of non-reset edges seen so far.
        m_mem[m_edges_since_reset] = 16'h0;
        if (mem_read_enable || mem_write_enable) m_rej++;
        m_edges_since_reset++;
      end else begin
        if (mem_read_enable) begin
          m_out = m_mem[mem_address];
          m_rd++;
        end
        if (mem_write_enable) begin
          m_mem[mem_address] = mem_data_in;
          m_wr++;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare both instances against the model on every cycle once reset has been seen.
  always @(negedge clk) begin
    if (m_valid) begin
      check("init_done_a", {31'd0, done_a}, {31'd0, m_ready()});
      check("init_done_b", {31'd0, done_b}, {31'd0, m_ready()});
      check("state_dbg_a", {31'd0, st_a}, {31'd0, m_ready()});
      check("dout_a", {16'd0, dout_a}, {16'd0, m_out});
      check("dout_b", {16'd0, dout_b}, {16'd0, m_out});
      check("rd_count_a", {16'd0, rd_a}, sat(m_rd, 16));
      check("wr_count_a", {16'd0, wr_a}, sat(m_wr, 16));
      check("rej_count_a", {16'd0, rej_a}, sat(m_rej, 16));
      check("rd_count_b", {28'd0, rd_b}, sat(m_rd, 4));
      check("wr_count_b", {28'd0, wr_b}, sat(m_wr, 4));
      check("rej_count_b", {28'd0, rej_b}, sat(m_rej, 4));
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic apply_reset();
    reset = 1'b1; mem_read_enable = 1'b0; mem_write_enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_sweep();
    repeat (31) @(negedge clk);
    check("lit_done_after31", {31'd0, done_a}, 32'd0);
    @(negedge clk);
    check("lit_done_after32", {31'd0, done_a}, 32'd1);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [15:0] d);
    mem_address = a; mem_data_in = d; mem_write_enable = 1'b1;
    @(negedge clk);
    mem_write_enable = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a);
    mem_address = a; mem_read_enable = 1'b1;
    @(negedge clk);
    mem_read_enable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_address = '0; mem_read_enable = 1'b0;
    mem_write_enable = 1'b0; mem_data_in = '0;
    repeat (2) @(negedge clk);
    check("lit_reset_done", {31'd0, done_a}, 32'd0);
    check("lit_reset_dout", {16'd0, dout_a}, 32'h0);

    // T1: sweep timing, then a cleared word reads as zero
    apply_reset();
    wait_sweep();
    do_read(5'd7);
    check("lit_t1_read7", {16'd0, dout_a}, 32'h0000);

    // T2: write then read back, fresh counters
    apply_reset();
    wait_sweep();
    do_write(5'd3, 16'h1234);
    do_read(5'd3);
    check("lit_t2_read3", {16'd0, dout_a}, 32'h1234);
    check("lit_t2_wr", {16'd0, wr_a}, 32'd1);
    check("lit_t2_rd", {16'd0, rd_a}, 32'd1);

    // T3: same-edge read+write returns old word, then new word
    do_write(5'd5, 16'hAAAA);
    mem_address = 5'd5; mem_data_in = 16'h5555;
    mem_read_enable = 1'b1; mem_write_enable = 1'b1;
    @(negedge clk);
    mem_read_enable = 1'b0; mem_write_enable = 1'b0;
    check("lit_t3_old", {16'd0, dout_a}, 32'hAAAA);
    do_read(5'd5);
    check("lit_t3_new", {16'd0, dout_a}, 32'h5555);
    check("lit_t3_wr", {16'd0, wr_a}, 32'd3);
    check("lit_t3_rd", {16'd0, rd_a}, 32'd3);

    // T4: write during the sweep is rejected
    apply_reset();
    repeat (9) @(negedge clk);
    mem_address = 5'd9; mem_data_in = 16'hBEEF; mem_write_enable = 1'b1;
    @(negedge clk);
    mem_write_enable = 1'b0;
    check("lit_t4_reject", {16'd0, rej_a}, 32'd1);
    check("lit_t4_wr", {16'd0, wr_a}, 32'd0);
    repeat (22) @(negedge clk);
    check("lit_t4_done", {31'd0, done_a}, 32'd1);
    do_read(5'd9);
    check("lit_t4_read9", {16'd0, dout_a}, 32'h0000);

    // T5: mid-operation reset wipes data and counters
    for (int i = 1; i <= 4; i++) do_write(i[4:0], 16'h00FF);
    do_read(5'd2);
    check("lit_t5_pre", {16'd0, dout_a}, 32'h00FF);
    apply_reset();
    check("lit_t5_rd0", {16'd0, rd_a}, 32'd0);
    check("lit_t5_wr0", {16'd0, wr_a}, 32'd0);
    check("lit_t5_done0", {31'd0, done_a}, 32'd0);
    check("lit_t5_dout0", {16'd0, dout_a}, 32'h0);
    wait_sweep();
    do_read(5'd2);
    check("lit_t5_read2", {16'd0, dout_a}, 32'h0000);

    // T6: 4-bit counters saturate at 15 and stay there
    apply_reset();
    wait_sweep();
    for (int i = 0; i < 20; i++) do_read(i[4:0]);
    check("lit_t6_rd_sat", {28'd0, rd_b}, 32'd15);
    check("lit_t6_wr_sat", {28'd0, wr_b}, 32'd0);
    check("lit_t6_rd_wide", {16'd0, rd_a}, 32'd20);
    do_read(5'd31);
    check("lit_t6_rd_hold", {28'd0, rd_b}, 32'd15);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
